// File: rtl/xilly_mem_pkg.sv
// Shared defaults, RAM depth helper and the host/app collision policy for the Xillybus memory bridge.
package xilly_mem_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [0:0] {
    HOST_WINS = 1'b0
  } coll_policy_e;

  localparam coll_policy_e COLL_POLICY = HOST_WINS;

  function automatic int depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/xilly_dp_ram.sv
// True dual-port RAM, read-before-write on both ports, 1-cycle registered reads held between enables.
// No reset and no backpressure; port A is written last so it wins a same-address write.
module xilly_dp_ram
  import xilly_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              a_we,
  input  logic              a_re,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_we,
  input  logic              b_re,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata
);

  logic [DATA_W-1:0] mem [depth(ADDR_W)];
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  always_ff @(posedge clk) begin
    if (a_re) a_rdata_q <= mem[a_addr];
    if (b_re) b_rdata_q <= mem[b_addr];
    if (b_we) mem[b_addr] <= b_wdata;
    if (a_we) mem[a_addr] <= a_wdata;
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/xilly_mem_bridge.sv
// Seekable host/app memory bridge; host and app reads return 1 cycle after the strobe. No backpressure
// in wrap mode; with XILLY_MEM_BOUND_EN the pointer saturates at depth and full/empty/eof block the host.
module xilly_mem_bridge
  import xilly_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              bus_clk,
  input  logic              bus_rst,
  input  logic              user_w_mem_wren,
  input  logic [DATA_W-1:0] user_w_mem_data,
  output logic              user_w_mem_full,
  input  logic              user_w_mem_open,
  input  logic              user_r_mem_rden,
  output logic [DATA_W-1:0] user_r_mem_data,
  output logic              user_r_mem_empty,
  output logic              user_r_mem_eof,
  input  logic              user_r_mem_open,
  input  logic [ADDR_W-1:0] user_mem_addr,
  input  logic              user_mem_addr_update,
  input  logic              app_we,
  input  logic              app_re,
  input  logic [ADDR_W-1:0] app_addr,
  input  logic [DATA_W-1:0] app_wdata,
  output logic [DATA_W-1:0] app_rdata,
  output logic              app_collision
);

`ifdef XILLY_MEM_BOUND_EN
  localparam int PTR_W = ADDR_W + 1;
`else
  localparam int PTR_W = ADDR_W;
`endif

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              host_vld_q, host_vld_d;
  logic              app_vld_q, app_vld_d;
  logic              coll_q, coll_d;
  logic              flag_q, flag_d;
  logic              at_end;
  logic              wr_go, rd_go, app_we_go;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] ram_host_rdata, ram_app_rdata;

`ifdef XILLY_MEM_BOUND_EN
  assign at_end = ptr_q[ADDR_W];
`else
  assign at_end = 1'b0;
`endif

  always_comb begin
    // A seek retargets this cycle's strobes, so the end-of-file block only applies without one.
    host_addr = user_mem_addr_update ? user_mem_addr : ptr_q[ADDR_W-1:0];
    wr_go     = user_w_mem_wren & user_w_mem_open & (user_mem_addr_update | ~at_end);
    rd_go     = user_r_mem_rden & user_r_mem_open & (user_mem_addr_update | ~at_end);

    ptr_d = user_mem_addr_update ? PTR_W'(user_mem_addr) : ptr_q;
    if (wr_go | rd_go) ptr_d = ptr_d + PTR_W'(1);

    coll_d    = (COLL_POLICY == HOST_WINS) & wr_go & app_we & (app_addr == host_addr);
    app_we_go = app_we & ~coll_d;

    host_vld_d = host_vld_q | rd_go;
    app_vld_d  = app_vld_q | app_re;

`ifdef XILLY_MEM_BOUND_EN
    flag_d = ptr_d[ADDR_W];
`else
    flag_d = 1'b0;
`endif
  end

  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      ptr_q      <= '0;
      host_vld_q <= 1'b0;
      app_vld_q  <= 1'b0;
      coll_q     <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      host_vld_q <= host_vld_d;
      app_vld_q  <= app_vld_d;
      coll_q     <= coll_d;
      flag_q     <= flag_d;
    end
  end

  xilly_dp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (bus_clk),
    .a_we    (wr_go),
    .a_re    (rd_go),
    .a_addr  (host_addr),
    .a_wdata (user_w_mem_data),
    .a_rdata (ram_host_rdata),
    .b_we    (app_we_go),
    .b_re    (app_re),
    .b_addr  (app_addr),
    .b_wdata (app_wdata),
    .b_rdata (ram_app_rdata)
  );

  // The RAM read registers have no reset; the valid flops blank them until a post-reset read lands.
  assign user_r_mem_data  = host_vld_q ? ram_host_rdata : '0;
  assign app_rdata        = app_vld_q ? ram_app_rdata : '0;
  assign app_collision    = coll_q;
  assign user_w_mem_full  = flag_q;
  assign user_r_mem_empty = flag_q;
  assign user_r_mem_eof   = flag_q;

endmodule

// File: tb/tb_xilly_mem_bridge.sv
// Scoreboard bench for xilly_mem_bridge: reference memory/pointer model, read results queued at drive time.
module tb_xilly_mem_bridge;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
`ifdef XILLY_MEM_BOUND_EN
  localparam bit BOUND = 1'b1;
`else
  localparam bit BOUND = 1'b0;
`endif

  logic          bus_clk = 1'b0;
  logic          bus_rst;
  logic          user_w_mem_wren;
  logic [DW-1:0] user_w_mem_data;
  logic          user_w_mem_full;
  logic          user_w_mem_open;
  logic          user_r_mem_rden;
  logic [DW-1:0] user_r_mem_data;
  logic          user_r_mem_empty;
  logic          user_r_mem_eof;
  logic          user_r_mem_open;
  logic [AW-1:0] user_mem_addr;
  logic          user_mem_addr_update;
  logic          app_we;
  logic          app_re;
  logic [AW-1:0] app_addr;
  logic [DW-1:0] app_wdata;
  logic [DW-1:0] app_rdata;
  logic          app_collision;

  always #5 bus_clk = ~bus_clk;

  xilly_mem_bridge #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .bus_clk              (bus_clk),
    .bus_rst              (bus_rst),
    .user_w_mem_wren      (user_w_mem_wren),
    .user_w_mem_data      (user_w_mem_data),
    .user_w_mem_full      (user_w_mem_full),
    .user_w_mem_open      (user_w_mem_open),
    .user_r_mem_rden      (user_r_mem_rden),
    .user_r_mem_data      (user_r_mem_data),
    .user_r_mem_empty     (user_r_mem_empty),
    .user_r_mem_eof       (user_r_mem_eof),
    .user_r_mem_open      (user_r_mem_open),
    .user_mem_addr        (user_mem_addr),
    .user_mem_addr_update (user_mem_addr_update),
    .app_we               (app_we),
    .app_re               (app_re),
    .app_addr             (app_addr),
    .app_wdata            (app_wdata),
    .app_rdata            (app_rdata),
    .app_collision        (app_collision)
  );

  logic [DW-1:0] model [DEPTH];
  int            ptr_m;
  logic [DW-1:0] host_q[$];
  logic [DW-1:0] app_q[$];
  logic [DW-1:0] last_host_m;
  logic [DW-1:0] last_app_m;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic clear_strobes();
    user_mem_addr_update = 1'b0;
    user_w_mem_wren      = 1'b0;
    user_r_mem_rden      = 1'b0;
    app_we               = 1'b0;
    app_re               = 1'b0;
  endtask

  // One bus cycle: drive, update the reference model, then pop and compare everything the DUT produced.
  task automatic drive_cycle(input bit upd, input int haddr, input bit wr, input logic [DW-1:0] wd,
                             input bit rd, input bit awe, input bit are, input int aaddr,
                             input logic [DW-1:0] awd, input string tag);
    int addr;
    bit wr_ok, rd_ok, coll_m, flag_m;
    user_mem_addr_update = upd;
    user_mem_addr        = haddr[AW-1:0];
    user_w_mem_wren      = wr;
    user_w_mem_data      = wd;
    user_r_mem_rden      = rd;
    app_we               = awe;
    app_re               = are;
    app_addr             = aaddr[AW-1:0];
    app_wdata            = awd;

    addr  = upd ? haddr : ptr_m;
    wr_ok = wr && user_w_mem_open && (upd || ptr_m != DEPTH);
    rd_ok = rd && user_r_mem_open && (upd || ptr_m != DEPTH);
    coll_m = wr_ok && awe && (addr == aaddr);
    if (rd_ok) host_q.push_back(model[addr]);
    if (are)   app_q.push_back(model[aaddr]);
    if (wr_ok) model[addr] = wd;
    if (awe && !coll_m) model[aaddr] = awd;
    ptr_m = addr + ((wr_ok || rd_ok) ? 1 : 0);
    if (!BOUND) ptr_m = ptr_m % DEPTH;
    flag_m = (ptr_m == DEPTH);

    tick();
    clear_strobes();
    while (host_q.size() > 0) last_host_m = host_q.pop_front();
    while (app_q.size() > 0)  last_app_m  = app_q.pop_front();
    check_val({tag, ".rdata"}, 32'(user_r_mem_data), 32'(last_host_m));
    check_val({tag, ".app_rdata"}, 32'(app_rdata), 32'(last_app_m));
    check_val({tag, ".collision"}, 32'(app_collision), 32'(coll_m));
    check_val({tag, ".full"}, 32'(user_w_mem_full), 32'(flag_m));
    check_val({tag, ".empty"}, 32'(user_r_mem_empty), 32'(flag_m));
    check_val({tag, ".eof"}, 32'(user_r_mem_eof), 32'(flag_m));
  endtask

  task automatic seek(input int a);
    drive_cycle(1'b1, a, 1'b0, '0, 1'b0, 1'b0, 1'b0, 0, '0, "seek");
  endtask
  task automatic hwrite(input logic [DW-1:0] d, input string tag);
    drive_cycle(1'b0, 0, 1'b1, d, 1'b0, 1'b0, 1'b0, 0, '0, tag);
  endtask
  task automatic hread(input string tag);
    drive_cycle(1'b0, 0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 0, '0, tag);
  endtask
  task automatic app_write(input int a, input logic [DW-1:0] d, input string tag);
    drive_cycle(1'b0, 0, 1'b0, '0, 1'b0, 1'b1, 1'b0, a, d, tag);
  endtask
  task automatic app_read(input int a, input string tag);
    drive_cycle(1'b0, 0, 1'b0, '0, 1'b0, 1'b0, 1'b1, a, '0, tag);
  endtask
  task automatic idle(input string tag);
    drive_cycle(1'b0, 0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 0, '0, tag);
  endtask

  initial begin
    bus_rst         = 1'b1;
    user_w_mem_open = 1'b1;
    user_r_mem_open = 1'b1;
    user_mem_addr   = '0;
    user_w_mem_data = '0;
    app_addr        = '0;
    app_wdata       = '0;
    clear_strobes();
    ptr_m       = 0;
    last_host_m = '0;
    last_app_m  = '0;
    tick();
    tick();
    check_val("rst.rdata", 32'(user_r_mem_data), 32'h0);
    check_val("rst.app_rdata", 32'(app_rdata), 32'h0);
    check_val("rst.collision", 32'(app_collision), 32'h0);
    check_val("rst.full", 32'(user_w_mem_full), 32'h0);
    check_val("rst.eof", 32'(user_r_mem_eof), 32'h0);
    bus_rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) app_write(i, DW'(i * 7 + 3), "init");

    // Seek, burst write, seek back, burst read; the fourth read proves the pointer sits at 6.
    seek(3);
    hwrite(8'hA1, "wr_a1");
    hwrite(8'hA2, "wr_a2");
    hwrite(8'hA3, "wr_a3");
    seek(3);
    hread("rd_a1");
    hread("rd_a2");
    hread("rd_a3");
    idle("hold");
    hread("rd_ptr6");

    // Wrap past the top address.
    seek(31);
    hwrite(8'h11, "wrap_w31");
    hwrite(8'h22, "wrap_w0");
    app_read(31, "wrap_r31");
    app_read(0, "wrap_r0");

    // Same-address host and app writes: host wins, collision pulses for one cycle.
    seek(7);
    drive_cycle(1'b0, 0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 7, 8'hAA, "coll");
    idle("coll_clr");
    app_read(7, "coll_ram7");
    drive_cycle(1'b0, 0, 1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 9, 8'h99, "nocoll");
    app_read(8, "nocoll_r8");
    app_read(9, "nocoll_r9");

    // Host read against app write at the same address sees the old word.
    seek(12);
    drive_cycle(1'b0, 0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 12, 8'h5A, "rd_vs_app");
    app_read(12, "rd_vs_app_ram");

    // Seek with a read in the same cycle, then the follow-on read.
    drive_cycle(1'b1, 9, 1'b0, '0, 1'b1, 1'b0, 1'b0, 0, '0, "seek_rd9");
    hread("rd10");

    // Simultaneous host read and write at one address, single pointer step.
    drive_cycle(1'b0, 0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 0, '0, "rw11");
    hread("rd12");
    seek(11);
    hread("rd11_new");

    // Closed files ignore strobes and hold the pointer.
    user_w_mem_open = 1'b0;
    user_r_mem_open = 1'b0;
    drive_cycle(1'b0, 0, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 0, '0, "closed");
    user_w_mem_open = 1'b1;
    user_r_mem_open = 1'b1;
    hread("reopen_rd");

`ifdef XILLY_MEM_BOUND_EN
    seek(31);
    hwrite(8'h31, "bnd_w31");
    hwrite(8'hEE, "bnd_wr_ign");
    hread("bnd_rd_ign");
    app_read(31, "bnd_r31");
    app_read(0, "bnd_r0");
    seek(0);
    idle("bnd_clr");
`endif

    // Reset in the middle of a read burst.
    app_read(5, "pre_rst_app");
    seek(0);
    hread("pre_rst_rd");
    user_r_mem_rden = 1'b1;
    #3;
    bus_rst = 1'b1;
    #1;
    check_val("rst_mid.rdata", 32'(user_r_mem_data), 32'h0);
    check_val("rst_mid.app_rdata", 32'(app_rdata), 32'h0);
    clear_strobes();
    tick();
    bus_rst = 1'b0;
    ptr_m       = 0;
    last_host_m = '0;
    last_app_m  = '0;
    host_q.delete();
    app_q.delete();
    idle("post_rst");
    hread("post_rst_rd0");
    app_read(5, "post_rst_ram5");
    app_read(12, "post_rst_ram12");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
